// File: rtl/intd_pkg.sv
// Shared types, defaults and decode helper for interrupt_dispatcher.
package intd_pkg;

  localparam int INTD_ID_W    = 2;
  localparam int INTD_NUM_IRQ = 1 << INTD_ID_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intd_state_t;

  // One bit of a one-hot decode; callers loop over the line index.
  function automatic logic intd_onehot_bit(input int id, input int idx);
    return (id == idx);
  endfunction

endpackage

// File: rtl/intd_timeout_cnt.sv
// Saturating acknowledge-timeout counter; o_tc is high while enabled at ACK_TIMEOUT-1.
module intd_timeout_cnt #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] LP_TC = 8'(ACK_TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_TC)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = i_en && (r_cnt == LP_TC);

endmodule

// File: rtl/interrupt_dispatcher.sv
// Registers the priority encoder winner into an irq_req/irq_ack/EOI handshake with one-hot pending clear.
// Optional single-level preemption when INTD_NEST_EN is defined.
module interrupt_dispatcher
  import intd_pkg::*;
#(
  parameter int NUM_IRQ     = INTD_NUM_IRQ,
  parameter int ID_W        = INTD_ID_W,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [ID_W-1:0]    y_in,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_clr,
  output logic               in_service,
  output logic               timeout
);

  intd_state_t        r_state;
  logic               r_irq_req;
  logic [ID_W-1:0]    r_irq_id;
  logic [NUM_IRQ-1:0] r_irq_clr;
  logic               r_in_service;
  logic               r_timeout;

  intd_state_t        w_state_nxt;
  logic               w_req_nxt;
  logic [ID_W-1:0]    w_id_nxt;
  logic [NUM_IRQ-1:0] w_clr_nxt;
  logic               w_svc_nxt;
  logic               w_to_nxt;
  logic [NUM_IRQ-1:0] w_onehot;
  logic               w_tc;
  logic               w_cnt_en;
  logic               w_cnt_clr;

`ifdef INTD_NEST_EN
  logic               r_nested;
  logic [ID_W-1:0]    r_stack_id;
  logic               w_nested_nxt;
  logic [ID_W-1:0]    w_stack_nxt;
`endif

  assign w_cnt_en  = (r_state == ST_REQ);
  assign w_cnt_clr = (r_state != ST_REQ) || irq_ack || w_tc;

  intd_timeout_cnt #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_tc (w_tc)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_onehot[i] = intd_onehot_bit(int'(r_irq_id), i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_irq_req;
    w_id_nxt    = r_irq_id;
    w_clr_nxt   = '0;
    w_svc_nxt   = r_in_service;
    w_to_nxt    = 1'b0;
`ifdef INTD_NEST_EN
    w_nested_nxt = r_nested;
    w_stack_nxt  = r_stack_id;
`endif
    case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          w_id_nxt    = y_in;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack wins over a timeout landing in the same cycle; EOI is never looked at here.
        if (irq_ack) begin
          w_req_nxt   = 1'b0;
          w_clr_nxt   = w_onehot;
          w_svc_nxt   = 1'b1;
          w_state_nxt = ST_SERVICE;
        end else if (w_tc) begin
          w_req_nxt   = 1'b0;
          w_to_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
`ifdef INTD_NEST_EN
          if (r_nested) begin
            w_id_nxt     = r_stack_id;
            w_nested_nxt = 1'b0;
            w_state_nxt  = ST_SERVICE;
          end
`endif
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          w_svc_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
`ifdef INTD_NEST_EN
          if (r_nested) begin
            w_svc_nxt    = 1'b1;
            w_id_nxt     = r_stack_id;
            w_nested_nxt = 1'b0;
            w_state_nxt  = ST_SERVICE;
          end
        end else if (!r_nested && valid_in && (y_in < r_irq_id)) begin
          w_stack_nxt  = r_irq_id;
          w_id_nxt     = y_in;
          w_req_nxt    = 1'b1;
          w_nested_nxt = 1'b1;
          w_state_nxt  = ST_REQ;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_irq_req    <= 1'b0;
      r_irq_id     <= '0;
      r_irq_clr    <= '0;
      r_in_service <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_req    <= w_req_nxt;
      r_irq_id     <= w_id_nxt;
      r_irq_clr    <= w_clr_nxt;
      r_in_service <= w_svc_nxt;
      r_timeout    <= w_to_nxt;
    end
  end

`ifdef INTD_NEST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nested   <= 1'b0;
      r_stack_id <= '0;
    end else begin
      r_nested   <= w_nested_nxt;
      r_stack_id <= w_stack_nxt;
    end
  end
`endif

  assign irq_req    = r_irq_req;
  assign irq_id     = r_irq_id;
  assign irq_clr    = r_irq_clr;
  assign in_service = r_in_service;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed table-driven bench for interrupt_dispatcher (ACK_TIMEOUT=4), plus timeout and nesting sequences.
module tb_interrupt_dispatcher;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [1:0] y_in;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] irq_clr;
  logic       in_service;
  logic       timeout;

  int n_total;
  int n_bad;

  interrupt_dispatcher #(
    .NUM_IRQ    (4),
    .ID_W       (2),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .y_in      (y_in),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_clr   (irq_clr),
    .in_service(in_service),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [1:0] y;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [1:0] id;
    logic [3:0] clr;
    logic       svc;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic r, input logic v, input logic [1:0] y,
                              input logic a, input logic e, input logic req, input logic [1:0] id,
                              input logic [3:0] clr, input logic svc, input logic to);
    vec_t t;
    t.name = name; t.rst = r; t.vld = v; t.y = y; t.ack = a; t.eoi = e;
    t.req = req; t.id = id; t.clr = clr; t.svc = svc; t.to = to;
    tbl.push_back(t);
  endfunction

  // Drive inputs, let one rising edge pass, then compare all outputs 1 time unit later.
  task automatic step(input vec_t t);
    logic [8:0] got;
    logic [8:0] exp;
    rst = t.rst; valid_in = t.vld; y_in = t.y; irq_ack = t.ack; irq_eoi = t.eoi;
    @(posedge clk);
    #1;
    got = {irq_req, irq_id, irq_clr, in_service, timeout};
    exp = {t.req, t.id, t.clr, t.svc, t.to};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got req=%b id=%0d clr=%b svc=%b to=%b, want req=%b id=%0d clr=%b svc=%b to=%b",
               t.name, irq_req, irq_id, irq_clr, in_service, timeout,
               t.req, t.id, t.clr, t.svc, t.to);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; valid_in = 1'b0; y_in = 2'd0; irq_ack = 1'b0; irq_eoi = 1'b0;

    //   name            rst  vld  y     ack  eoi   req  id    clr      svc  to
    add("reset",        1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd0,4'b0000,1'b0,1'b0);
    add("idle",         1'b0,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd0,4'b0000,1'b0,1'b0);
    add("idle_ack_eoi", 1'b0,1'b0,2'd0,1'b1,1'b1, 1'b0,2'd0,4'b0000,1'b0,1'b0);
    add("req_id2",      1'b0,1'b1,2'd2,1'b0,1'b0, 1'b1,2'd2,4'b0000,1'b0,1'b0);
    add("req_frozen",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b1,2'd2,4'b0000,1'b0,1'b0);
    add("ack_id2",      1'b0,1'b0,2'd0,1'b1,1'b0, 1'b0,2'd2,4'b0100,1'b1,1'b0);
    add("clr_falls",    1'b0,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("svc_ack_ign",  1'b0,1'b0,2'd0,1'b1,1'b0, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("svc_vld_low",  1'b0,1'b1,2'd3,1'b0,1'b0, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("eoi_id2",      1'b0,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd2,4'b0000,1'b0,1'b0);
    add("req_id3",      1'b0,1'b1,2'd3,1'b0,1'b0, 1'b1,2'd3,4'b0000,1'b0,1'b0);
    add("id3_frozen",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b1,2'd3,4'b0000,1'b0,1'b0);
    add("vld_drop_hold",1'b0,1'b0,2'd0,1'b0,1'b0, 1'b1,2'd3,4'b0000,1'b0,1'b0);
    add("ack_eoi_same", 1'b0,1'b0,2'd0,1'b1,1'b1, 1'b0,2'd3,4'b1000,1'b1,1'b0);
    add("eoi_id3",      1'b0,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd3,4'b0000,1'b0,1'b0);
    add("req_id1",      1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("rst_in_req",   1'b1,1'b1,2'd1,1'b1,1'b0, 1'b0,2'd0,4'b0000,1'b0,1'b0);
    add("req_id1_b",    1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("ack_id1",      1'b0,1'b0,2'd0,1'b1,1'b0, 1'b0,2'd1,4'b0010,1'b1,1'b0);
    add("svc_id1",      1'b0,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd1,4'b0000,1'b1,1'b0);
    add("rst_in_svc",   1'b1,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd0,4'b0000,1'b0,1'b0);
    add("post_rst",     1'b0,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd0,4'b0000,1'b0,1'b0);

    // Timeout: request high for exactly 4 cycles, one timeout pulse, re-raised while valid stays up.
    add("to_req1",      1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("to_req2",      1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("to_req3",      1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("to_req4",      1'b0,1'b1,2'd1,1'b0,1'b0, 1'b1,2'd1,4'b0000,1'b0,1'b0);
    add("to_pulse",     1'b0,1'b1,2'd1,1'b0,1'b0, 1'b0,2'd1,4'b0000,1'b0,1'b1);
    add("to_reraise",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b1,2'd0,4'b0000,1'b0,1'b0);
    add("to_ack_edge",  1'b0,1'b0,2'd0,1'b0,1'b0, 1'b1,2'd0,4'b0000,1'b0,1'b0);
    add("to_rst",       1'b1,1'b0,2'd0,1'b0,1'b0, 1'b0,2'd0,4'b0000,1'b0,1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Preemption sequence: servicing ID 2 when a higher-priority ID 0 arrives.
    tbl.delete();
    add("n_req2",       1'b0,1'b1,2'd2,1'b0,1'b0, 1'b1,2'd2,4'b0000,1'b0,1'b0);
    add("n_ack2",       1'b0,1'b0,2'd0,1'b1,1'b0, 1'b0,2'd2,4'b0100,1'b1,1'b0);
`ifdef INTD_NEST_EN
    add("n_preempt0",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b1,2'd0,4'b0000,1'b1,1'b0);
    add("n_no_2nd",     1'b0,1'b0,2'd0,1'b0,1'b0, 1'b1,2'd0,4'b0000,1'b1,1'b0);
    add("n_ack0",       1'b0,1'b0,2'd0,1'b1,1'b0, 1'b0,2'd0,4'b0001,1'b1,1'b0);
    add("n_eoi0",       1'b0,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("n_eoi2",       1'b0,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd2,4'b0000,1'b0,1'b0);
`else
    add("n_vld_ign",    1'b0,1'b1,2'd0,1'b0,1'b0, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("n_vld_ign2",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b0,2'd2,4'b0000,1'b1,1'b0);
    add("n_eoi2",       1'b0,1'b0,2'd0,1'b0,1'b1, 1'b0,2'd2,4'b0000,1'b0,1'b0);
`endif
    add("n_gap_req0",   1'b0,1'b1,2'd0,1'b0,1'b0, 1'b1,2'd0,4'b0000,1'b0,1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_dispatcher.md
# interrupt_dispatcher

Sits directly downstream of `priority_encoder` and turns its combinational winner (`y`, `valid`) into a registered interrupt request to the CPU core. It latches the winning ID and holds it stable through an `irq_req`/`irq_ack` handshake. On acknowledge it pulses a one-hot clear back to the pending-interrupt register. It then tracks the in-service interrupt until the CPU signals end-of-interrupt (EOI).

## Interface
- `NUM_IRQ`, default 4: number of interrupt lines; must equal 2^`ID_W`.
- `ID_W`, default 2: width of the interrupt ID; matches the encoder's `y` output.
- `ACK_TIMEOUT`, default 255: cycles `irq_req` may stay high unacknowledged before withdrawal; valid range 2..255.
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_in` input 1: encoder `valid`.
- `y_in` input `ID_W`: encoder `y`; lower value is higher priority.
- `irq_ack` input 1: CPU accepts the current request.
- `irq_eoi` input 1: CPU finished servicing; single-cycle pulse.
- `irq_req` output 1: request to CPU.
- `irq_id` output `ID_W`: ID of the requested or in-service interrupt.
- `irq_clr` output `NUM_IRQ`: one-hot, one-cycle clear pulse to the pending register.
- `in_service` output 1: an interrupt is being serviced.
- `timeout` output 1: one-cycle pulse when a request is withdrawn.

## Operation
- All outputs are registered.
- Reset values: `irq_req`=0, `irq_id`=0, `irq_clr`=0, `in_service`=0, `timeout`=0; state IDLE; timeout counter 0.
- **IDLE:**
  - On `valid_in`=1, latch `y_in` into `irq_id`, set `irq_req`=1 and go to REQ.
  - `irq_ack` and `irq_eoi` are ignored.
- **REQ:**
  - `irq_id` is frozen; changes on `y_in`/`valid_in` are ignored.
  - On `irq_ack`=1: `irq_req`←0, `irq_clr`←one-hot(`irq_id`) for one cycle, `in_service`←1, go to SERVICE.
  - If `irq_eoi` arrives in the same cycle as `irq_ack`, the EOI is ignored.
  - The counter increments every cycle in REQ. If it reaches `ACK_TIMEOUT`-1 with no ack: `irq_req`←0, `timeout` pulses, counter clears, go to IDLE.
  - After a timeout, pending is not cleared, so the encoder re-presents the line and arbitration is redone.
- **SERVICE:**
  - `irq_id` holds the serviced ID.
  - On `irq_eoi`=1: `in_service`←0, go to IDLE.
  - `irq_ack` is ignored.
  - Without `INTD_NEST_EN`, `valid_in` is ignored.
- `valid_in` deasserting while in REQ does not withdraw the request; only ack, timeout or reset end it.
- Reset asserted in any state forces the reset values on the next edge. No `irq_clr` pulse is emitted.

## Timing
- `valid_in` sampled at edge N → `irq_req`=1 and `irq_id` valid after edge N.
- `irq_ack` sampled at edge M → `irq_req`=0, `irq_clr` pulse and `in_service`=1 after edge M. `irq_clr` falls after edge M+1.
- `irq_eoi` sampled at edge K → `in_service`=0 after edge K. A new `valid_in` is sampled at K+1 at the earliest, so there is a minimum 1-cycle gap between services.
- Timeout: with `irq_req` first high at cycle R, it is withdrawn after `ACK_TIMEOUT` cycles. It is re-raised at the earliest 2 cycles later.

## Configuration
- Macro: `INTD_NEST_EN`. The nesting depth is fixed at 1.
- **With the macro defined**, in SERVICE:
  - If `valid_in`=1 and `y_in` < `irq_id`, save `irq_id` into a stack register, latch `y_in`, raise `irq_req` and go to REQ with the `nested` flag set.
  - `in_service` stays 1 throughout.
  - A nested ack pulses `irq_clr` for the new ID.
  - A nested EOI restores the saved ID and returns to SERVICE, not IDLE.
  - A nested timeout also restores the saved ID and returns to SERVICE.
  - While `nested` is set, no further preemption is possible.
- **Without the macro:** there is no stack register, and `valid_in` is ignored in SERVICE.

## Structure
- Shared package `intd_pkg` holds:
  - the state enum (IDLE, REQ, SERVICE);
  - the `ID_W`/`NUM_IRQ` defaults;
  - the one-hot decode function used for `irq_clr`.
- One sub-module, `intd_timeout_cnt`: a saturating counter with clear/enable inputs and a terminal-count pulse, parameterised by `ACK_TIMEOUT`.

## Test plan
- `valid_in`=1, `y_in`=2 → `irq_req`=1 and `irq_id`=2 one cycle later. Ack → `irq_clr`=4'b0100 for one cycle, `in_service`=1. EOI → `in_service`=0.
- In REQ with `irq_id`=3, change `y_in` to 0 → `irq_id` stays 3 until ack.
- `ACK_TIMEOUT`=4, never ack → `irq_req` high for exactly 4 cycles, then one `timeout` pulse, no `irq_clr`. The request is re-raised if `valid_in` remains 1.
- Simultaneous `irq_ack` and `irq_eoi` in REQ → enter SERVICE, `in_service` remains 1.
- Assert `rst` mid-SERVICE and mid-REQ → all outputs 0 after the next edge, and no `irq_clr` pulse.
- With `INTD_NEST_EN`, servicing ID 2 when `y_in`=0 arrives → nested request for ID 0, `irq_clr`=4'b0001 on ack. Nested EOI → `irq_id`=2, `in_service`=1. Second EOI → IDLE.
